imem_port_arbiter: RTL and testbench



---
 rtl/imem_port_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_imem_port_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_port_arbiter.sv
// imem_port_arbiter: shares the 256x8 imem between queued host writes and CPU fetches.
// Optional feature: define IMEM_WR_COUNT_EN to add the wr_count commit counter port.
module imem_port_arbiter #(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        host_we,
  input  logic [7:0]  host_addr,
  input  logic [7:0]  host_data,
  input  logic        cpu_fetch_req,
  input  logic [7:0]  cpu_pc,
  output logic [7:0]  cpu_instr,
  output logic        cpu_instr_valid,
  output logic [7:0]  mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [7:0]  mem_rdata,
  output logic        fifo_full,
  output logic        overflow
`ifdef IMEM_WR_COUNT_EN
  ,
  output logic [15:0] wr_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [CW-1:0] LIMIT    = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [7:0]       f_addr [DEPTH];
  logic [7:0]       f_data [DEPTH];
  logic [DEPTH-1:0] f_vld;
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic [AW:0]      count_q;
  logic [AW:0]      count_d;

  logic          full;
  logic          empty;
  logic          push;
  logic          pop;
  logic          ovf_set;
  logic          hazard;
  logic          force_rd;
  logic [CW-1:0] starve_q;
  logic [CW-1:0] starve_inc;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);

  // Match the fetch address against every write still waiting in the FIFO.
  always_comb begin
    hazard = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (f_vld[i] && (f_addr[i] == cpu_pc)) begin
        hazard = 1'b1;
      end
    end
  end

  // Starvation bookkeeping: saturating increment and the forced-fetch condition.
  always_comb begin
    starve_inc = (starve_q == LIMIT) ? LIMIT : starve_q + 1'b1;
    force_rd   = cpu_fetch_req && !hazard && (starve_q == LIMIT);
  end

  // Next-state: forced fetch, then pending writes, then a plain fetch.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (force_rd) begin
          state_d = READ;
        end else if (!empty) begin
          state_d = WRITE;
          pop     = 1'b1;
        end else if (cpu_fetch_req) begin
          state_d = READ;
        end
      end
      WRITE:   state_d = IDLE;
      READ:    state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // A push is accepted when there is room now or a slot frees this cycle.
  always_comb begin
    push    = host_we && (!full || pop);
    ovf_set = host_we && full && !pop;
    count_d = count_q
            + {{AW{1'b0}}, push}
            - {{AW{1'b0}}, pop};
  end

  // State register.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FIFO pointers, occupancy and per-slot valid flags.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
      f_vld   <= '0;
    end else begin
      if (pop) begin
        f_vld[rd_ptr] <= 1'b0;
        rd_ptr        <= rd_ptr + 1'b1;
      end
      if (push) begin
        f_vld[wr_ptr] <= 1'b1;
        wr_ptr        <= wr_ptr + 1'b1;
      end
      count_q <= count_d;
    end
  end

  // FIFO payload storage; contents are don't-care while the slot is invalid.
  always_ff @(posedge wb_clk_i) begin
    if (push) begin
      f_addr[wr_ptr] <= host_addr;
      f_data[wr_ptr] <= host_data;
    end
  end

  // Registered imem port, CPU response, status flags and starvation count.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      mem_we          <= 1'b0;
      mem_re          <= 1'b0;
      mem_addr        <= '0;
      mem_wdata       <= '0;
      cpu_instr       <= '0;
      cpu_instr_valid <= 1'b0;
      fifo_full       <= 1'b0;
      overflow        <= 1'b0;
      starve_q        <= '0;
    end else begin
      mem_we          <= 1'b0;
      mem_re          <= 1'b0;
      cpu_instr_valid <= 1'b0;
      fifo_full       <= (count_d == FULL_CNT);
      if (ovf_set) begin
        overflow <= 1'b1;
      end
      unique case (state_q)
        IDLE: begin
          if (pop) begin
            mem_we    <= 1'b1;
            mem_addr  <= f_addr[rd_ptr];
            mem_wdata <= f_data[rd_ptr];
          end else if (state_d == READ) begin
            mem_re   <= 1'b1;
            mem_addr <= cpu_pc;
          end
        end
        WRITE: begin
          starve_q <= cpu_fetch_req ? starve_inc : '0;
        end
        READ: begin
        end
        RESP: begin
          cpu_instr       <= mem_rdata;
          cpu_instr_valid <= 1'b1;
          starve_q        <= '0;
        end
        default: begin
        end
      endcase
    end
  end

`ifdef IMEM_WR_COUNT_EN
  // Saturating count of write commits.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wr_count <= '0;
    end else if ((state_q == WRITE) && (wr_count != 16'hFFFF)) begin
      wr_count <= wr_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_imem_port_arbiter.sv
// tb_imem_port_arbiter: random + directed bench with a queue/array reference model.
// Builds with or without IMEM_WR_COUNT_EN.
module tb_imem_port_arbiter;

  localparam int DEPTH = 4;
  localparam int LIM   = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       host_we = 1'b0;
  logic [7:0] host_addr = '0;
  logic [7:0] host_data = '0;
  logic       cpu_fetch_req = 1'b0;
  logic [7:0] cpu_pc = '0;
  logic [7:0] cpu_instr;
  logic       cpu_instr_valid;
  logic [7:0] mem_addr;
  logic [7:0] mem_wdata;
  logic       mem_we;
  logic       mem_re;
  logic [7:0] mem_rdata;
  logic       fifo_full;
  logic       overflow;
`ifdef IMEM_WR_COUNT_EN
  logic [15:0] wr_count;
`endif

  always #5 clk = ~clk;

  imem_port_arbiter #(
    .DEPTH(DEPTH),
    .STARVE_LIMIT(LIM)
  ) dut (
    .wb_clk_i(clk),
    .wb_rst_i(rst),
    .host_we(host_we),
    .host_addr(host_addr),
    .host_data(host_data),
    .cpu_fetch_req(cpu_fetch_req),
    .cpu_pc(cpu_pc),
    .cpu_instr(cpu_instr),
    .cpu_instr_valid(cpu_instr_valid),
    .mem_addr(mem_addr),
    .mem_wdata(mem_wdata),
    .mem_we(mem_we),
    .mem_re(mem_re),
    .mem_rdata(mem_rdata),
    .fifo_full(fifo_full),
    .overflow(overflow)
`ifdef IMEM_WR_COUNT_EN
    ,
    .wr_count(wr_count)
`endif
  );

  logic [7:0] mem [256];
  bit         mem_init = 1'b1;

  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h5A;
    end else begin
      if (mem_we) mem[mem_addr] <= mem_wdata;
      if (mem_re) mem_rdata <= mem[mem_addr];
    end
  end

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  wr_t        fq[$];
  logic [7:0] gm [256];
  bit         exp_ovf;
  bit         fpend;
  bit         re_seen;
  bit         t5;
  bit         got_re;
  bit         got_valid;
  logic [7:0] exp_instr;
  int vec, errs, cyc;
  int re_cyc, req_cyc, we_cyc;
  int starve_seen, n_commit, n_valid;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    vec++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic start_fetch(input logic [7:0] pc);
    cpu_fetch_req = 1'b1;
    cpu_pc        = pc;
    fpend         = 1'b1;
    re_seen       = 1'b0;
    req_cyc       = cyc;
    starve_seen   = 0;
  endtask

  task automatic step();
    bit         in_we  = host_we;
    bit         in_rst = rst;
    logic [7:0] in_a   = host_addr;
    logic [7:0] in_d   = host_data;
    logic [7:0] in_pc  = cpu_pc;
    bit         hz     = 1'b0;
    bit         popped = 1'b0;
    int         pre_n;
    wr_t        e;
    if (fpend && mem_we && cpu_fetch_req) starve_seen++;
    pre_n = fq.size();
    foreach (fq[i]) if (fq[i].a == in_pc) hz = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
    got_re    = mem_re;
    got_valid = cpu_instr_valid;
    if (in_rst) begin
      fq.delete();
      exp_ovf       = 1'b0;
      fpend         = 1'b0;
      cpu_fetch_req = 1'b0;
      check("rst_outs", {cpu_instr, cpu_instr_valid, mem_addr, mem_wdata,
                         mem_we, mem_re, fifo_full, overflow}, '0);
`ifdef IMEM_WR_COUNT_EN
      check("rst_wr_count", wr_count, '0);
`endif
      return;
    end
    check("we_re_excl", mem_we & mem_re, 1'b0);
    if (mem_re) begin
      check("re_expected", fpend & ~re_seen, 1'b1);
      check("re_addr", mem_addr, in_pc);
      check("re_hazard", hz, 1'b0);
      exp_instr = gm[in_pc];
      re_seen   = 1'b1;
      re_cyc    = cyc;
      if (t5) check("starve_grant", starve_seen, LIM);
    end
    if (mem_we) begin
      n_commit++;
      we_cyc = cyc;
      if (fq.size() == 0) begin
        check("we_unexpected", 1'b1, 1'b0);
      end else begin
        e      = fq.pop_front();
        popped = 1'b1;
        check("we_addr", mem_addr, e.a);
        check("we_data", mem_wdata, e.d);
        gm[e.a] = e.d;
      end
    end
    if (in_we) begin
      if (pre_n < DEPTH || popped) begin
        e.a = in_a;
        e.d = in_d;
        fq.push_back(e);
      end else begin
        exp_ovf = 1'b1;
      end
    end
    check("overflow", overflow, exp_ovf);
    check("fifo_full", fifo_full, fq.size() == DEPTH);
    if (cpu_instr_valid) begin
      n_valid++;
      check("valid_expected", fpend & re_seen, 1'b1);
      check("valid_latency", cyc - re_cyc, 2);
      check("instr", cpu_instr, exp_instr);
      fpend         = 1'b0;
      cpu_fetch_req = 1'b0;
    end else if (fpend && (cyc - req_cyc > 300)) begin
      check("fetch_timeout", 1'b0, 1'b1);
      fpend         = 1'b0;
      cpu_fetch_req = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic push(input logic [7:0] a, input logic [7:0] d);
    host_we   = 1'b1;
    host_addr = a;
    host_data = d;
    step();
    host_we = 1'b0;
  endtask

  task automatic run_fetch(input logic [7:0] pc, output int lr, output int lv);
    int t0;
    start_fetch(pc);
    t0 = cyc;
    lr = -1;
    lv = -1;
    for (int k = 0; k < 50 && lv < 0; k++) begin
      step();
      if (got_re) lr = cyc - t0;
      if (got_valid) lv = cyc - t0;
    end
    if (lv < 0) check("run_fetch_timeout", 1'b0, 1'b1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    host_we = 1'b0;
    step();
    rst = 1'b0;
  endtask

  initial begin
    int lr, lv, done;
    for (int i = 0; i < 256; i++) gm[i] = 8'(i) ^ 8'h5A;
    step();
    step();
    mem_init = 1'b0;
    rst = 1'b0;
    idle(2);

    n_commit = 0;
    push(8'h10, 8'hA5);
    idle(5);
    check("t1_commits", n_commit, 1);
    check("t1_overflow", overflow, 1'b0);

    run_fetch(8'h10, lr, lv);
    check("t2_re_lat", lr, 1);
    check("t2_valid_lat", lv, 3);
    check("t2_instr", cpu_instr, 8'hA5);
    idle(2);

    n_commit = 0;
    for (int k = 0; k < 10; k++) push(8'h40 + 8'(k), 8'hC0 + 8'(k));
    idle(12);
    check("t3_overflow", overflow, 1'b1);
    check("t3_commits", n_commit, 9);

    do_reset();
    idle(1);
    push(8'h20, 8'h3C);
    run_fetch(8'h20, lr, lv);
    check("t4_order", we_cyc < re_cyc, 1'b1);
    check("t4_instr", cpu_instr, 8'h3C);
    idle(2);

    do_reset();
    t5 = 1'b1;
    done = 0;
    for (int k = 0; k < 80 && done < 2; k++) begin
      host_we   = 1'b1;
      host_addr = 8'h30 + 8'(k % 8);
      host_data = 8'($urandom);
      if (!fpend && (k == 3 || done == 1)) start_fetch(8'h05);
      step();
      if (got_valid) done++;
    end
    check("t5_fetches", done, 2);
    t5 = 1'b0;
    host_we = 1'b0;
    idle(12);

    do_reset();
    idle(1);
    start_fetch(8'h33);
    host_we   = 1'b1;
    host_addr = 8'h34;
    host_data = 8'h77;
    step();
    check("t6_in_read", got_re, 1'b1);
    host_addr = 8'h35;
    rst = 1'b1;
    step();
    rst = 1'b0;
    host_we = 1'b0;
    n_commit = 0;
    n_valid = 0;
    idle(8);
    check("t6_commits", n_commit, 0);
    check("t6_valids", n_valid, 0);
    check("t6_full", fifo_full, 1'b0);

    for (int k = 0; k < 1500; k++) begin
      host_we   = ($urandom_range(0, 99) < 45);
      host_addr = 8'($urandom_range(0, 15));
      host_data = 8'($urandom);
      if (!fpend && $urandom_range(0, 9) < 3) begin
        if (fq.size() > 0 && $urandom_range(0, 1) == 1)
          start_fetch(fq[$urandom_range(0, fq.size() - 1)].a);
        else
          start_fetch(8'($urandom_range(0, 15)));
      end
      step();
    end
    host_we = 1'b0;
    for (int k = 0; k < 100 && fpend; k++) step();
    idle(12);

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

endmodule
